barcode_period_meter: RTL

Measures the period of the raw barcode square wave and presents a filtered, averaged period word to the SPI output stage. It sits directly upstream of the SPI shifter in `top`: it consumes the asynchronous `signal` input and produces the word and `done` strobe that the shifter loads.

- Chip enable low freezes this block's output register so a word never changes mid-transfer.
- The MCU converts the period word to a tuning word.

---
 rtl/barcode_period_meter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/barcode_period_meter.sv
// barcode_period_meter
// Measures the period between debounced rising edges of an asynchronous
// barcode square wave, averages the last four accepted periods and posts
// the result as a word plus a one-cycle done strobe. A hold input keeps
// the output word frozen while a downstream transfer is in progress.
module barcode_period_meter #(
  parameter int COUNT_W    = 24,
  parameter int STABLE     = 4,
  parameter int MIN_PERIOD = 8,
  parameter int TIMEOUT    = 2**20
) (
  input  logic               sck,
  input  logic               reset,
  input  logic               signal,
  input  logic               hold,
  output logic [COUNT_W-1:0] period_word,
  output logic               done,
  output logic               nosig
);

  localparam int                 RUN_W    = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam logic [RUN_W-1:0]   RUN_LAST = RUN_W'(STABLE - 1);
  localparam logic [RUN_W-1:0]   RUN_ONE  = RUN_W'(1);
  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] MIN_VAL  = COUNT_W'(MIN_PERIOD);
  localparam logic [COUNT_W-1:0] TMO_VAL  = COUNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN
  } state_t;

  // synchronizer and debounce
  logic             sync1_q;
  logic             sync2_q;
  logic             clean_q;
  logic             cleanPrev_q;
  logic [RUN_W-1:0] runCnt_q;

  // measurement FSM and history
  state_t           state_q;
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;
  logic [COUNT_W-1:0] hist_q [4];
  logic             nosig_q;
  logic             sampleValid_q;

  // averaging stage
  logic [COUNT_W+1:0] sum_d;
  logic [COUNT_W-1:0] avg_d;
  logic [COUNT_W-1:0] avg_q;
  logic               avgValid_q;

  // output stage
  logic               postValid_d;
  logic [COUNT_W-1:0] postWord_d;
  logic [COUNT_W-1:0] period_word_q;
  logic               done_q;
  logic [COUNT_W-1:0] pending_q;
  logic               pendingValid_q;

  // event decode
  logic edgeSeen;
  logic timeoutHit;
  logic longEnough;

  assign period_word = period_word_q;
  assign done        = done_q;
  assign nosig       = nosig_q;

  // Bring the raw input into the sck domain and only let the debounced level flip after STABLE consecutive disagreeing samples.
  always_ff @(posedge sck) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      clean_q     <= 1'b0;
      cleanPrev_q <= 1'b0;
      runCnt_q    <= '0;
    end else begin
      sync1_q     <= signal;
      sync2_q     <= sync1_q;
      cleanPrev_q <= clean_q;
      if (sync2_q != clean_q) begin
        if (runCnt_q == RUN_LAST) begin
          clean_q  <= ~clean_q;
          runCnt_q <= '0;
        end else begin
          runCnt_q <= runCnt_q + RUN_ONE;
        end
      end else begin
        runCnt_q <= '0;
      end
    end
  end

  // Decode edge/timeout events, saturating count, history average and the value offered to the output stage.
  always_comb begin
    edgeSeen    = clean_q & ~cleanPrev_q;
    timeoutHit  = (state_q != IDLE) && (cnt_q == TMO_VAL);
    longEnough  = (cnt_q >= MIN_VAL);
    cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    sum_d       = {2'b00, hist_q[0]} + {2'b00, hist_q[1]} +
                  {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
    avg_d       = COUNT_W'(sum_d >> 2);
    postValid_d = timeoutHit | avgValid_q;
    postWord_d  = timeoutHit ? '0 : avg_q;
  end

  // Measurement FSM: the first edge arms, long-enough edges prime or shift the history, and a silent input times out back to IDLE.
  always_ff @(posedge sck) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      nosig_q       <= 1'b1;
      sampleValid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      sampleValid_q <= 1'b0;
      cnt_q         <= cnt_d;
      if (timeoutHit) begin
        nosig_q <= 1'b1;
        for (int i = 0; i < 4; i++) begin
          hist_q[i] <= '0;
        end
        if (edgeSeen) begin
          state_q <= ARMED;
          cnt_q   <= CNT_ONE;
        end else begin
          state_q <= IDLE;
        end
      end else if (edgeSeen) begin
        case (state_q)
          IDLE: begin
            state_q <= ARMED;
            cnt_q   <= CNT_ONE;
          end
          ARMED: begin
            if (longEnough) begin
              for (int i = 0; i < 4; i++) begin
                hist_q[i] <= cnt_q;
              end
              nosig_q       <= 1'b0;
              state_q       <= RUN;
              cnt_q         <= CNT_ONE;
              sampleValid_q <= 1'b1;
            end
          end
          RUN: begin
            if (longEnough) begin
              hist_q[3]     <= hist_q[2];
              hist_q[2]     <= hist_q[1];
              hist_q[1]     <= hist_q[0];
              hist_q[0]     <= cnt_q;
              cnt_q         <= CNT_ONE;
              sampleValid_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // Register the floor average one cycle after the history settles.
  always_ff @(posedge sck) begin
    if (reset) begin
      avg_q      <= '0;
      avgValid_q <= 1'b0;
    end else begin
      avg_q      <= avg_d;
      avgValid_q <= sampleValid_q;
    end
  end

  // Output register: posts go straight out unless held, in which case the newest post waits in pending until hold drops.
  always_ff @(posedge sck) begin
    if (reset) begin
      period_word_q  <= '0;
      done_q         <= 1'b0;
      pending_q      <= '0;
      pendingValid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (postValid_d) begin
        if (!hold) begin
          period_word_q  <= postWord_d;
          done_q         <= 1'b1;
          pendingValid_q <= 1'b0;
        end else begin
          pending_q      <= postWord_d;
          pendingValid_q <= 1'b1;
        end
      end else if (!hold && pendingValid_q) begin
        period_word_q  <= pending_q;
        done_q         <= 1'b1;
        pendingValid_q <= 1'b0;
      end
    end
  end

endmodule
